// File: rtl/hazard_ctrl.sv
// Hazard controller for the non-forwarding 5-stage core: RAW interlock against an
// in-flight destination scoreboard, redirect flush, memory-wait freeze, debug counters.
module hazard_ctrl #(
   parameter int unsigned HAZ_DEPTH = 3,
   parameter int unsigned RF_BYPASS = 1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_id_valid,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_use_rs1,
   input  logic             i_id_use_rs2,
   input  logic [4:0]       i_id_rd,
   input  logic             i_id_regwrite,
   input  logic             i_ex_redirect,
   input  logic             i_mem_busy,
   output logic             o_pc_stall,
   output logic             o_if_id_stall,
   output logic             o_if_id_flush,
   output logic             o_id_ex_stall,
   output logic             o_id_ex_flush,
   output logic             o_back_stall,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam int unsigned NBLK = HAZ_DEPTH - RF_BYPASS;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_RAW   = 2'd1;
   localparam logic [1:0] ST_MEMW  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [HAZ_DEPTH-1:0] r_sb_v;
   logic [4:0]           r_sb_rd [HAZ_DEPTH];
   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_stall_cnt;
   logic [CNT_W-1:0]     r_flush_cnt;

   logic       w_raw;
   logic [1:0] w_state;

   // Only the first NBLK entries can block; later ones are covered by the regfile bypass.
   always_comb begin
      w_raw = 1'b0;
      for (int k = 0; k < int'(NBLK); k++) begin
         if (r_sb_v[k] && (r_sb_rd[k] != 5'd0)) begin
            if (i_id_use_rs1 && (i_id_rs1 != 5'd0) && (i_id_rs1 == r_sb_rd[k])) w_raw = 1'b1;
            if (i_id_use_rs2 && (i_id_rs2 != 5'd0) && (i_id_rs2 == r_sb_rd[k])) w_raw = 1'b1;
         end
      end
      w_raw = w_raw & i_id_valid;
   end

   always_comb begin
      if (i_mem_busy)         w_state = ST_MEMW;
      else if (i_ex_redirect) w_state = ST_FLUSH;
      else if (w_raw)         w_state = ST_RAW;
      else                    w_state = ST_RUN;
   end

   always_comb begin
      o_pc_stall    = 1'b0;
      o_if_id_stall = 1'b0;
      o_if_id_flush = 1'b0;
      o_id_ex_stall = 1'b0;
      o_id_ex_flush = 1'b0;
      o_back_stall  = 1'b0;
      if (i_reset_n) begin
         case (w_state)
            ST_MEMW: begin
               o_pc_stall    = 1'b1;
               o_if_id_stall = 1'b1;
               o_id_ex_stall = 1'b1;
               o_back_stall  = 1'b1;
            end
            ST_FLUSH: begin
               o_if_id_flush = 1'b1;
               o_id_ex_flush = 1'b1;
            end
            ST_RAW: begin
               o_pc_stall    = 1'b1;
               o_if_id_stall = 1'b1;
               o_id_ex_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_sb_v      <= '0;
         for (int k = 0; k < int'(HAZ_DEPTH); k++) r_sb_rd[k] <= 5'd0;
         r_state     <= ST_RUN;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state;
         // Pipe advances unless frozen; RAW and FLUSH both enter a bubble.
         if (w_state != ST_MEMW) begin
            for (int k = int'(HAZ_DEPTH) - 1; k > 0; k--) begin
               r_sb_v[k]  <= r_sb_v[k-1];
               r_sb_rd[k] <= r_sb_rd[k-1];
            end
            r_sb_v[0]  <= (w_state == ST_RUN) && i_id_valid && i_id_regwrite;
            r_sb_rd[0] <= i_id_rd;
         end
         if (((w_state == ST_RAW) || (w_state == ST_MEMW)) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if ((w_state == ST_FLUSH) && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign o_state     = r_state;
   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios then random traffic, checked against a
// per-register countdown model; a CNT_W=4 instance shares the stimulus for saturation.
module tb_hazard_ctrl;

   localparam int NBLK = 2;

   logic       clk = 1'b0;
   logic       rst_n, id_valid, use1, use2, regwrite, redirect, mem_busy;
   logic [4:0] rs1, rs2, rd;

   logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, back_stall;
   logic [1:0]  state;
   logic [31:0] stall_cnt, flush_cnt;

   logic       pc_stall4, if_id_stall4, if_id_flush4, id_ex_stall4, id_ex_flush4, back_stall4;
   logic [1:0] state4;
   logic [3:0] stall_cnt4, flush_cnt4;

   int checks = 0;
   int errors = 0;

   // Model: cycles each register stays unreadable, counted in advancing pipe cycles.
   int          rem [32];
   logic [1:0]  e_state;
   logic [31:0] e_stall, e_flush;
   logic [3:0]  e_stall4, e_flush4;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
      .i_id_rd(rd), .i_id_regwrite(regwrite), .i_ex_redirect(redirect), .i_mem_busy(mem_busy),
      .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_if_id_flush(if_id_flush),
      .o_id_ex_stall(id_ex_stall), .o_id_ex_flush(id_ex_flush), .o_back_stall(back_stall),
      .o_state(state), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_reset_n(rst_n), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
      .i_id_rd(rd), .i_id_regwrite(regwrite), .i_ex_redirect(redirect), .i_mem_busy(mem_busy),
      .o_pc_stall(pc_stall4), .o_if_id_stall(if_id_stall4), .o_if_id_flush(if_id_flush4),
      .o_id_ex_stall(id_ex_stall4), .o_id_ex_flush(id_ex_flush4), .o_back_stall(back_stall4),
      .o_state(state4), .o_stall_cnt(stall_cnt4), .o_flush_cnt(flush_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode: -1 reset, 0 run, 1 raw, 2 mem wait, 3 flush
   task automatic step(input logic rn, input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic [4:0] d, input logic w,
                       input logic r, input logic m);
      int   mode;
      logic raw;
      logic [5:0] e_ctl;
      @(negedge clk);
      rst_n = rn; id_valid = v; rs1 = a; rs2 = b; use1 = ua; use2 = ub;
      rd = d; regwrite = w; redirect = r; mem_busy = m;
      #1;
      raw = v && ((ua && (a != 0) && (rem[a] > 0)) || (ub && (b != 0) && (rem[b] > 0)));
      if (!rn)      mode = -1;
      else if (m)   mode = 2;
      else if (r)   mode = 3;
      else if (raw) mode = 1;
      else          mode = 0;
      e_ctl = {(mode == 1 || mode == 2), (mode == 1 || mode == 2), (mode == 3),
               (mode == 2), (mode == 1 || mode == 3), (mode == 2)};
      chk("ctl", {26'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                  back_stall}, {26'd0, e_ctl});
      chk("ctl4", {26'd0, pc_stall4, if_id_stall4, if_id_flush4, id_ex_stall4, id_ex_flush4,
                   back_stall4}, {26'd0, e_ctl});
      @(posedge clk);
      if (mode < 0) begin
         for (int i = 0; i < 32; i++) rem[i] = 0;
         e_state = 2'd0; e_stall = 0; e_flush = 0; e_stall4 = 0; e_flush4 = 0;
      end else begin
         e_state = 2'(mode);
         if (mode != 2) begin
            for (int i = 0; i < 32; i++) if (rem[i] > 0) rem[i]--;
            if (mode == 0 && v && w && d != 0) rem[d] = NBLK;
         end
         if (mode == 1 || mode == 2) begin
            if (e_stall != 32'hFFFF_FFFF) e_stall++;
            if (e_stall4 != 4'hF) e_stall4++;
         end
         if (mode == 3) begin
            if (e_flush != 32'hFFFF_FFFF) e_flush++;
            if (e_flush4 != 4'hF) e_flush4++;
         end
      end
      #1;
      chk("state", {30'd0, state}, {30'd0, e_state});
      chk("stall_cnt", stall_cnt, e_stall);
      chk("flush_cnt", flush_cnt, e_flush);
      chk("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, e_stall4});
      chk("flush_cnt4", {28'd0, flush_cnt4}, {28'd0, e_flush4});
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
      rd = 5'd0; regwrite = 1'b0; redirect = 1'b0; mem_busy = 1'b0;
      for (int i = 0; i < 32; i++) rem[i] = 0;
      e_state = 2'd0; e_stall = 0; e_flush = 0; e_stall4 = 0; e_flush4 = 0;

      // Reset, including a request that would otherwise stall
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Producer x5 then dependent consumer: two RAW cycles then issue
      step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
      step(1, 1, 5, 0, 1, 0, 6, 1, 0, 0);
      chk("t1_state_raw", {30'd0, state}, 32'd1);
      step(1, 1, 5, 0, 1, 0, 6, 1, 0, 0);
      step(1, 1, 5, 0, 1, 0, 6, 1, 0, 0);
      chk("t1_stall_total", stall_cnt, 32'd2);
      chk("t1_issue_state", {30'd0, state}, 32'd0);

      // x0 never blocks
      step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 1, 1, 7, 1, 0, 0);
      chk("t2_state_run", {30'd0, state}, 32'd0);

      // Redirect colliding with RAW wins
      step(1, 1, 0, 0, 0, 0, 8, 1, 0, 0);
      step(1, 1, 8, 0, 1, 0, 9, 1, 1, 0);
      chk("t3_state_flush", {30'd0, state}, 32'd3);
      chk("t3_flush_cnt", flush_cnt, 32'd1);
      step(1, 1, 8, 0, 1, 0, 9, 1, 0, 0);
      step(1, 1, 8, 0, 1, 0, 9, 1, 0, 0);

      // RAW interrupted by three memory-wait cycles
      step(1, 1, 0, 0, 0, 0, 10, 1, 0, 0);
      step(1, 1, 0, 10, 0, 1, 11, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 10, 0, 1, 11, 1, 0, 1);
      chk("t4_state_memw", {30'd0, state}, 32'd2);
      step(1, 1, 0, 10, 0, 1, 11, 1, 0, 0);
      step(1, 1, 0, 10, 0, 1, 11, 1, 0, 0);

      // Reset in the middle of a RAW stall clears the scoreboard and counters
      step(1, 1, 0, 0, 0, 0, 12, 1, 0, 0);
      step(1, 1, 12, 0, 1, 0, 13, 1, 0, 0);
      step(0, 1, 12, 0, 1, 0, 13, 1, 0, 0);
      step(1, 1, 12, 0, 1, 0, 13, 1, 0, 0);
      chk("t5_state_run", {30'd0, state}, 32'd0);
      chk("t5_stall_zero", stall_cnt, 32'd0);

      // Counter saturation on the narrow instance
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("t6_sat4", {28'd0, stall_cnt4}, 32'd15);
      chk("t6_wide", stall_cnt, 32'd20);

      // Random traffic over a small register set to provoke collisions
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 99) >= 3), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
